// File: rtl/onehot_grant_dispatcher_pkg.sv
// Shared types and helpers for the one-hot grant dispatcher.
// Holds the FSM state encoding and the index-to-one-hot decode.
package onehot_grant_dispatcher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Binary index to one-hot; callers slice the low N bits (N <= 32).
  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/onehot_grant_dispatcher_fifo.sv
// Synchronous FIFO with occupancy count; pushes are refused when full and
// pops are refused when empty. Pointers wrap naturally (DEPTH power of two).
module sync_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/onehot_grant_dispatcher.sv
// Buffers binary target indices and issues each as a registered one-hot
// grant held until ack or timeout, with one idle cycle between grants.
module onehot_grant_dispatcher
  import onehot_grant_dispatcher_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 3,
  parameter int DEPTH = 4,
  parameter int TMO   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_idx,
  input  logic                       ack,
  output logic [N-1:0]               gnt,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       idx_err,
  output logic                       tmo_err
);

  localparam int            TW     = (TMO > 0) ? $clog2(TMO+1) : 1;
  localparam logic [W:0]    N_LIM  = (W+1)'(N);
  localparam logic [TW-1:0] T_LAST = TW'((TMO > 0) ? TMO-1 : 0);

  state_t        state;
  logic [TW-1:0] timer;
  logic [W-1:0]  head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          idx_ok;
  logic          push;
  logic          pop;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign idx_ok   = ({1'b0, in_idx} < N_LIM);
  assign push     = accept && idx_ok;
  assign pop      = ((state == IDLE) || (state == GAP)) && !empty;
  assign busy     = (state != IDLE) || !empty;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_idx),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      timer   <= '0;
      idx_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      idx_err <= accept && !idx_ok;
      tmo_err <= 1'b0;
      case (state)
        // GAP shares the pop path with IDLE; gnt is already zero there.
        IDLE, GAP: begin
          if (pop) begin
            gnt   <= N'(onehot32(5'(head)));
            timer <= '0;
            state <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (ack) begin
            gnt   <= '0;
            state <= GAP;
          end else if ((TMO != 0) && (timer == T_LAST)) begin
            gnt     <= '0;
            tmo_err <= 1'b1;
            state   <= GAP;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_grant_dispatcher.sv
// Directed bench for onehot_grant_dispatcher: default instance (N=8) plus an
// N=6 instance for out-of-range index handling.
module tb_onehot_grant_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       ack;
  logic [7:0] gnt;
  logic       busy;
  logic [2:0] level;
  logic       idx_err;
  logic       tmo_err;

  logic       v6;
  logic       rdy6;
  logic [2:0] idx6;
  logic       ack6;
  logic [5:0] gnt6;
  logic       busy6;
  logic [2:0] level6;
  logic       idx_err6;
  logic       tmo_err6;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  grants[$];
  logic [7:0]  prev_gnt;

  always #5 clk = ~clk;

  onehot_grant_dispatcher #(.N(8), .W(3), .DEPTH(4), .TMO(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .ack(ack), .gnt(gnt), .busy(busy), .level(level),
    .idx_err(idx_err), .tmo_err(tmo_err)
  );

  onehot_grant_dispatcher #(.N(6), .W(3), .DEPTH(4), .TMO(16)) u_dut6 (
    .clk(clk), .reset(reset), .in_valid(v6), .in_ready(rdy6),
    .in_idx(idx6), .ack(ack6), .gnt(gnt6), .busy(busy6), .level(level6),
    .idx_err(idx_err6), .tmo_err(tmo_err6)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (gnt != 8'h00 && prev_gnt == 8'h00) grants.push_back(gnt);
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_idx = '0; ack = 1'b0;
    v6 = 1'b0; idx6 = '0; ack6 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    grants.delete();
    prev_gnt = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_gnt [17];
    logic [2:0] push_idx [3];
    logic [7:0] exp_oh;
    int unsigned n;

    // 1: reset values, single push, timeout after 16 grant cycles
    do_reset();
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_ready", 32'(in_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_level", 32'(level), 32'h0);
    check_eq("rst_idx_err", 32'(idx_err), 32'h0);
    check_eq("rst_tmo_err", 32'(tmo_err), 32'h0);
    in_valid = 1'b1; in_idx = 3'd5;
    tick();
    in_valid = 1'b0;
    check_eq("t1_no_bypass", 32'(gnt), 32'h0);
    check_eq("t1_level1", 32'(level), 32'h1);
    tick();
    for (int i = 0; i < 16; i++) begin
      check_eq("t1_gnt_hold", 32'(gnt), 32'h20);
      check_eq("t1_no_tmo", 32'(tmo_err), 32'h0);
      if (i < 15) tick();
    end
    tick();
    check_eq("t1_gnt_drop", 32'(gnt), 32'h0);
    check_eq("t1_tmo_pulse", 32'(tmo_err), 32'h1);
    tick();
    check_eq("t1_tmo_end", 32'(tmo_err), 32'h0);
    check_eq("t1_busy_end", 32'(busy), 32'h0);

    // 2: three back-to-back indices, each acked on its 4th grant cycle
    do_reset();
    exp_gnt = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h80, 8'h80, 8'h80,
                8'h80, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    push_idx = '{3'd2, 3'd7, 3'd0};
    for (int k = 0; k < 17; k++) begin
      in_valid = (k < 3);
      in_idx   = (k < 3) ? push_idx[k] : 3'd0;
      ack      = (k == 5 || k == 10 || k == 15);
      tick();
      check_eq($sformatf("t2_gnt_%0d", k), 32'(gnt), 32'(exp_gnt[k]));
      if (k == 2) check_eq("t2_level2", 32'(level), 32'h2);
    end
    ack = 1'b0; in_valid = 1'b0;
    check_eq("t2_busy_end", 32'(busy), 32'h0);

    // 3: six pushes with ack low; FIFO fills and the 6th waits for a pop
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_idx = 3'(k);
      tick();
    end
    check_eq("t3_full_level", 32'(level), 32'h4);
    check_eq("t3_not_ready", 32'(in_ready), 32'h0);
    in_idx = 3'd6;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("t3_stall_cycles", n, 32'd14);
    tick();
    in_valid = 1'b0;
    check_eq("t3_refill_level", 32'(level), 32'h4);
    ack = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    ack = 1'b0;
    check_eq("t3_drained", 32'(busy), 32'h0);
    check_eq("t3_grant_count", grants.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      exp_oh = 8'd1 << (i + 1);
      check_eq($sformatf("t3_grant_%0d", i),
               (i < grants.size()) ? 32'(grants[i]) : 32'hdead, 32'(exp_oh));
    end

    // 4: N=6 instance, out-of-range index is dropped with idx_err pulse
    do_reset();
    v6 = 1'b1; idx6 = 3'd7;
    tick();
    check_eq("t4_idx_err", 32'(idx_err6), 32'h1);
    check_eq("t4_level0", 32'(level6), 32'h0);
    idx6 = 3'd3;
    tick();
    v6 = 1'b0;
    check_eq("t4_idx_err_end", 32'(idx_err6), 32'h0);
    check_eq("t4_level1", 32'(level6), 32'h1);
    tick();
    check_eq("t4_gnt", 32'(gnt6), 32'h08);
    check_eq("t4_level_pop", 32'(level6), 32'h0);

    // 5: asynchronous reset during a grant with two entries queued
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_idx = 3'(k);
      tick();
    end
    in_valid = 1'b0;
    check_eq("t5_pre_gnt", 32'(gnt), 32'h02);
    check_eq("t5_pre_level", 32'(level), 32'h2);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_gnt", 32'(gnt), 32'h0);
    check_eq("t5_async_level", 32'(level), 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t5_no_stale", 32'(gnt), 32'h0);
    end
    check_eq("t5_busy", 32'(busy), 32'h0);
    check_eq("t5_tmo", 32'(tmo_err), 32'h0);

    // 6: ack held high through IDLE; grant lasts exactly one cycle
    do_reset();
    ack = 1'b1;
    tick(); tick(); tick();
    check_eq("t6_idle_gnt", 32'(gnt), 32'h0);
    check_eq("t6_idle_busy", 32'(busy), 32'h0);
    in_valid = 1'b1; in_idx = 3'd1;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("t6_gnt", 32'(gnt), 32'h02);
    tick();
    check_eq("t6_gap_gnt", 32'(gnt), 32'h0);
    check_eq("t6_gap_busy", 32'(busy), 32'h1);
    check_eq("t6_no_tmo", 32'(tmo_err), 32'h0);
    tick();
    check_eq("t6_end_gnt", 32'(gnt), 32'h0);
    check_eq("t6_end_busy", 32'(busy), 32'h0);
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
